bcsa_eru_pipe: RTL and testbench

Parametrised, pipelined block carry-select adder with an error-reduction unit (ERU) and a runtime exact/approximate mode. It is the next generation of the fixed 32-bit, 8-bit-block ERU adder and sits in the approximate-arithmetic datapath as a streaming operator. A valid/ready handshake supports backpressure. An error monitor compares each approximate result against the exact sum and counts mismatches for accuracy characterisation.

---
 rtl/bcsa_eru_pipe_if.sv | 31 +++
 rtl/bcsa_eru_pipe.sv | 119 +++++++++++
 tb/tb_bcsa_eru_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcsa_eru_pipe_if.sv
// Streaming handshake bundle for bcsa_eru_pipe.
//   master: operand producer / result consumer (drives in_valid, a, b, mode, out_ready)
//   slave : the adder pipeline (drives in_ready, out_valid, sum, out_err)
//   in_valid/in_ready   operand beat handshake
//   a, b, mode          operands; mode 1 = exact, 0 = approximate
//   out_valid/out_ready result beat handshake
//   sum                 WIDTH+1 result, MSB is carry-out
//   out_err             approximate result differs from exact sum
interface bcsa_eru_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             out_err;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, out_err
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, out_err
  );
endinterface

// File: rtl/bcsa_eru_pipe.sv
// Two-stage pipelined block carry-select adder with error-reduction unit
// and a per-beat exact/approximate mode. Stage 1 registers the operands,
// stage 2 registers the selected sum and the approximation-error flag.
// A saturating counter tallies delivered beats whose result was wrong.
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      slave side of bcsa_eru_pipe_if (operand and result handshakes)
//   cnt_clr  synchronous clear of err_cnt, wins over an increment
//   err_cnt  saturating count of delivered erroneous beats
module bcsa_eru_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  bcsa_eru_pipe_if.slave  bus,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] err_cnt
);
  localparam int N = WIDTH / BLK;

  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             mode1;
  logic             ov_q;
  logic [WIDTH:0]   sum_q;
  logic             err_q;
  logic             en1;
  logic             en2;
  logic [WIDTH:0]   exact_sum;
  logic [WIDTH:0]   approx_sum;

  // Stage 2 can take a new beat when empty or draining; stage 1 when empty
  // or when stage 2 frees up. No skid buffer, so in_ready sees out_ready.
  assign en2          = ~ov_q | bus.out_ready;
  assign en1          = ~v1 | en2;
  assign bus.in_ready = en1;
  assign bus.out_valid = ov_q;
  assign bus.sum       = sum_q;
  assign bus.out_err   = err_q;

  assign exact_sum = {1'b0, a1} + {1'b0, b1};

  for (genvar k = 0; k < N; k++) begin : g_blk
    logic cin;
    logic corr;

    if (k == 0) begin : g_first
      assign cin  = 1'b0;
      assign corr = 1'b0;
    end else begin : g_rest
      logic g_prev;
      logic zero_lsb;
      logic spec;
      assign g_prev   = a1[k*BLK-1] & b1[k*BLK-1];
      assign zero_lsb = ~a1[k*BLK] & ~b1[k*BLK];
      // Speculative carry is the previous block's generate (carry-in 0).
      assign spec     = 1'(({1'b0, a1[(k-1)*BLK +: BLK]} +
                            {1'b0, b1[(k-1)*BLK +: BLK]}) >> BLK);
      // When the boundary bits decide the carry locally, trust them;
      // otherwise fall back to the speculative carry.
      assign cin      = (g_prev | zero_lsb) ? g_prev : spec;
      // A dropped speculative carry into a 0+0 LSB is recovered exactly.
      assign corr     = zero_lsb & spec;
    end

    if (k == N-1) begin : g_top
      assign approx_sum[k*BLK +: BLK+1] =
        ({1'b0, a1[k*BLK +: BLK]} + {1'b0, b1[k*BLK +: BLK]} +
         {{BLK{1'b0}}, cin}) | {{BLK{1'b0}}, corr};
    end else begin : g_mid
      assign approx_sum[k*BLK +: BLK] =
        (a1[k*BLK +: BLK] + b1[k*BLK +: BLK] + {{(BLK-1){1'b0}}, cin}) |
        {{(BLK-1){1'b0}}, corr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      mode1 <= 1'b0;
    end else if (en1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        a1    <= bus.a;
        b1    <= bus.b;
        mode1 <= bus.mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q  <= 1'b0;
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (en2) begin
      ov_q <= v1;
      if (v1) begin
        sum_q <= mode1 ? exact_sum : approx_sum;
        err_q <= ~mode1 & (approx_sum != exact_sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (ov_q && bus.out_ready && err_q && (err_cnt != {CNTW{1'b1}})) begin
      err_cnt <= err_cnt + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_bcsa_eru_pipe.sv
// Self-checking bench for bcsa_eru_pipe: fixed vector table, directed
// backpressure / counter / reset sequences, and a randomized stream checked
// against a queue-based reference model of the pipeline.
module tb_bcsa_eru_pipe;
  localparam int WIDTH = 32;
  localparam int BLK   = 8;
  localparam int CNTW  = 2;
  localparam int N     = WIDTH / BLK;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cnt_clr = 1'b0;
  logic [CNTW-1:0] err_cnt;

  always #5 clk = ~clk;

  bcsa_eru_pipe_if #(.WIDTH(WIDTH)) bus ();

  bcsa_eru_pipe #(.WIDTH(WIDTH), .BLK(BLK), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .err_cnt (err_cnt)
  );

  typedef struct {
    logic [WIDTH:0] s;
    logic           e;
    int             t;
  } beat_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH:0]   s;
    logic             e;
  } vec_t;

  beat_t q[$];
  vec_t  vt[$];
  int    edges   = 0;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cnt_m   = 0;
  logic  last_oxf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact = plain addition; approximate = block-by-block rules.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic mode);
    longint unsigned av, bv, m, ak, bk, t, blk, r;
    int gp, zero, spec, ca, gprev_blk;
    av = 64'(a);
    bv = 64'(b);
    if (mode) return (WIDTH+1)'(av + bv);
    m = (64'd1 << BLK) - 1;
    r = 0;
    gprev_blk = 0;
    for (int k = 0; k < N; k++) begin
      ak = (av >> (k*BLK)) & m;
      bk = (bv >> (k*BLK)) & m;
      ca = 0; zero = 0; spec = 0;
      if (k > 0) begin
        gp   = int'((av >> (k*BLK-1)) & (bv >> (k*BLK-1)) & 64'd1);
        zero = (((av | bv) >> (k*BLK)) & 64'd1) == 0 ? 1 : 0;
        spec = gprev_blk;
        ca   = (gp != 0 || zero != 0) ? gp : spec;
      end
      t   = ak + bk + longint'(ca);
      blk = t & m;
      if (zero != 0 && spec != 0) blk = blk | 64'd1;
      r = r | (blk << (k*BLK));
      if (k == N-1) r = r | ((t >> BLK) << WIDTH);
      gprev_blk = (ak + bk > m) ? 1 : 0;
    end
    return (WIDTH+1)'(r);
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic m, input logic ordy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.mode      = m;
    bus.out_ready = ordy;
  endtask

  // One clock: check handshake before the edge, update model, check after.
  task automatic step();
    logic  ir_exp, ov_exp, ixf, clr;
    beat_t nb;
    #1;
    ov_exp = (q.size() > 0) && (edges - q[0].t >= 1);
    ir_exp = (q.size() < 2) || bus.out_ready;
    chk("in_ready", 64'(bus.in_ready), 64'(ir_exp));
    ixf      = bus.in_valid && ir_exp;
    last_oxf = ov_exp && bus.out_ready;
    clr      = cnt_clr;
    nb.s = ref_sum(bus.a, bus.b, bus.mode);
    nb.e = !bus.mode && (nb.s != ref_sum(bus.a, bus.b, 1'b1));
    nb.t = 0;
    @(posedge clk);
    edges++;
    if (clr) cnt_m = 0;
    else if (last_oxf && q[0].e && cnt_m < CMAX) cnt_m++;
    if (last_oxf) void'(q.pop_front());
    if (ixf) begin
      nb.t = edges;
      q.push_back(nb);
    end
    #1;
    ov_exp = (q.size() > 0) && (edges - q[0].t >= 1);
    chk("out_valid", 64'(bus.out_valid), 64'(ov_exp));
    if (ov_exp) begin
      chk("sum", 64'(bus.sum), 64'(q[0].s));
      chk("out_err", 64'(bus.out_err), 64'(q[0].e));
    end
    chk("err_cnt", 64'(err_cnt), 64'(cnt_m));
  endtask

  localparam logic [WIDTH-1:0] XA = 32'h1111_1111, XB = 32'h2222_2222;
  localparam logic [WIDTH-1:0] YA = 32'h00FF_FF80, YB = 32'h0000_0080;
  localparam logic [WIDTH-1:0] ZA = 32'h1234_5678, ZB = 32'h1111_1111;

  initial begin
    logic [WIDTH:0] got[$];
    int             expc[5];
    int             delivered, sent;
    logic           will;

    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #2;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst sum", 64'(bus.sum), 64'd0);
    chk("rst out_err", 64'(bus.out_err), 64'd0);
    chk("rst err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table ----------------
    vt.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h1_0000_0000, 1'b0});
    vt.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, 1'b0});
    vt.push_back('{32'h00FF_FF80, 32'h0000_0080, 1'b0, 33'h0_00FF_0000, 1'b1});
    vt.push_back('{32'h00FF_FF80, 32'h0000_0080, 1'b1, 33'h0_0100_0000, 1'b0});
    vt.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000, 1'b0});
    vt.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE, 1'b0});
    vt.push_back('{32'h0000_0180, 32'h0000_0080, 1'b0, 33'h0_0000_0200, 1'b0});
    vt.push_back('{32'h0000_FF80, 32'h0000_0080, 1'b0, 33'h0_0000_0000, 1'b1});
    vt.push_back('{32'h0000_0100, 32'h0000_00FF, 1'b0, 33'h0_0000_01FF, 1'b0});
    vt.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b0});
    vt.push_back('{32'h0000_00FF, 32'h0000_0101, 1'b0, 33'h0_0000_0200, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      drive(1'b1, vt[i].a, vt[i].b, vt[i].m, 1'b1);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      step();
      chk($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d sum", i), 64'(bus.sum), 64'(vt[i].s));
      chk($sformatf("vec%0d err", i), 64'(bus.out_err), 64'(vt[i].e));
    end
    step();

    // ---------------- backpressure ----------------
    drive(1'b1, XA, XB, 1'b1, 1'b0);
    step();
    drive(1'b1, YA, YB, 1'b0, 1'b0);
    step();
    drive(1'b1, ZA, ZB, 1'b1, 1'b0);
    #1;
    chk("bp in_ready low", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp hold valid", 64'(bus.out_valid), 64'd1);
      chk("bp hold sum", 64'(bus.sum), 64'h0_3333_3333);
    end
    drive(1'b1, ZA, ZB, 1'b1, 1'b1);
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (bus.out_valid && bus.out_ready) got.push_back(bus.sum);
      step();
      bus.in_valid = 1'b0;
    end
    chk("bp beats delivered", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp order 0", 64'(got[0]), 64'h0_3333_3333);
      chk("bp order 1", 64'(got[1]), 64'h0_00FF_0000);
      chk("bp order 2", 64'(got[2]), 64'h0_2345_6789);
    end
    step();

    // ---------------- saturating counter ----------------
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    expc = '{1, 2, 3, 3, 3};
    delivered = 0;
    sent = 0;
    drive(1'b1, YA, YB, 1'b0, 1'b1);
    for (int i = 0; i < 30 && delivered < 6; i++) begin
      if (delivered == 5 && bus.out_valid) cnt_clr = 1'b1;
      will = bus.out_valid;
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      cnt_clr = 1'b0;
      if (sent == 6) bus.in_valid = 1'b0;
      if (will) begin
        delivered++;
        if (delivered <= 5) chk($sformatf("cnt seq %0d", delivered), 64'(err_cnt), 64'(expc[delivered-1]));
        else chk("cnt clr wins", 64'(err_cnt), 64'd0);
      end
    end
    chk("cnt beats delivered", 64'(delivered), 64'd6);
    step();

    // ---------------- reset mid-stream ----------------
    drive(1'b1, YA, YB, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("pre-rst err_cnt", 64'(err_cnt), 64'd1);
    drive(1'b1, XA, XB, 1'b1, 1'b0);
    step();
    drive(1'b1, ZA, ZB, 1'b1, 1'b0);
    step();
    chk("pre-rst valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid-rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid-rst sum", 64'(bus.sum), 64'd0);
    chk("mid-rst err_cnt", 64'(err_cnt), 64'd0);
    chk("mid-rst in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    cnt_m = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
    step();
    chk("post-rst early valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    step();
    chk("post-rst valid", 64'(bus.out_valid), 64'd1);
    chk("post-rst sum", 64'(bus.sum), 64'h1_0000_0000);
    step();

    // ---------------- randomized stream ----------------
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.a         = $urandom;
      bus.b         = ($urandom % 4 == 0) ? ~bus.a + 32'($urandom % 3) : $urandom;
      bus.mode      = ($urandom % 3) == 0;
      bus.out_ready = ($urandom % 10) < 7;
      cnt_clr       = ($urandom % 40) == 0;
      step();
    end
    cnt_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("drain empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
